// File: rtl/time_counter_if.sv
// Button/tick inputs and BCD time outputs of the time-of-day counter.
// The bench or a top-level wrapper drives the master side; the counter is the slave.
interface time_counter_if;
  logic       clk_1Hz;
  logic       mode_btn;
  logic       inc_btn;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic [1:0] mode;
  logic       sec_pulse;
  logic       day_wrap;

  modport master (
    output clk_1Hz, mode_btn, inc_btn,
    input  hours, minutes, seconds, mode, sec_pulse, day_wrap
  );

  modport slave (
    input  clk_1Hz, mode_btn, inc_btn,
    output hours, minutes, seconds, mode, sec_pulse, day_wrap
  );
endinterface

// File: rtl/time_counter.sv
// Packed-BCD seconds/minutes/hours counter driven by a 1 Hz square wave,
// with a run / set-hours / set-minutes mode selected by button pulses.
module time_counter #(
  parameter bit H24      = 1'b1,
  parameter int INIT_HR  = 0,
  parameter int INIT_MIN = 0
) (
  input  logic          clk,
  input  logic          reset,
  time_counter_if.slave tc
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_e;

  // A 12-hour clock has no hour 0, so a zero preset means 12.
  localparam int         HR_BIN  = (!H24 && INIT_HR == 0) ? 12 : INIT_HR;
  localparam logic [7:0] HR_RST  = {4'(HR_BIN / 10), 4'(HR_BIN % 10)};
  localparam logic [7:0] MIN_RST = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10)};

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_wrap_inc(input logic [7:0] v,
                                              input logic [7:0] max_v,
                                              input logic [7:0] min_v);
    return (v == max_v) ? min_v : bcd_inc(v);
  endfunction

  function automatic logic [7:0] hour_next(input logic [7:0] v);
    return H24 ? bcd_wrap_inc(v, 8'h23, 8'h00) : bcd_wrap_inc(v, 8'h12, 8'h01);
  endfunction

  mode_e      state_q, state_d;
  logic [7:0] hours_q, hours_d;
  logic [7:0] minutes_q, minutes_d;
  logic [7:0] seconds_q, seconds_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       day_wrap_q, day_wrap_d;
  logic       clk_1hz_prev_q, clk_1hz_prev_d;
  logic       tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RUN;
      hours_q        <= HR_RST;
      minutes_q      <= MIN_RST;
      seconds_q      <= 8'h00;
      sec_pulse_q    <= 1'b0;
      day_wrap_q     <= 1'b0;
      clk_1hz_prev_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      hours_q        <= hours_d;
      minutes_q      <= minutes_d;
      seconds_q      <= seconds_d;
      sec_pulse_q    <= sec_pulse_d;
      day_wrap_q     <= day_wrap_d;
      clk_1hz_prev_q <= clk_1hz_prev_d;
    end
  end

  // Edge register presets high so a clk_1Hz already high at reset release is not a tick.
  assign tick = tc.clk_1Hz & ~clk_1hz_prev_q;

  always_comb begin
    state_d        = state_q;
    hours_d        = hours_q;
    minutes_d      = minutes_q;
    seconds_d      = seconds_q;
    sec_pulse_d    = 1'b0;
    day_wrap_d     = 1'b0;
    clk_1hz_prev_d = tc.clk_1Hz;

    case (state_q)
      RUN: begin
        if (tick) begin
          sec_pulse_d = 1'b1;
          if (seconds_q == 8'h59) begin
            seconds_d = 8'h00;
            if (minutes_q == 8'h59) begin
              minutes_d  = 8'h00;
              hours_d    = hour_next(hours_q);
              day_wrap_d = H24 ? (hours_q == 8'h23) : (hours_q == 8'h11);
            end else begin
              minutes_d = bcd_inc(minutes_q);
            end
          end else begin
            seconds_d = bcd_inc(seconds_q);
          end
        end
        // Carries from a coincident tick still land; only seconds are forced to zero.
        if (tc.mode_btn) begin
          state_d   = SET_HR;
          seconds_d = 8'h00;
        end
      end
      SET_HR: begin
        if (tc.inc_btn)  hours_d = hour_next(hours_q);
        if (tc.mode_btn) state_d = SET_MIN;
      end
      SET_MIN: begin
        if (tc.inc_btn)  minutes_d = bcd_wrap_inc(minutes_q, 8'h59, 8'h00);
        if (tc.mode_btn) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign tc.hours     = hours_q;
  assign tc.minutes   = minutes_q;
  assign tc.seconds   = seconds_q;
  assign tc.mode      = state_q;
  assign tc.sec_pulse = sec_pulse_q;
  assign tc.day_wrap  = day_wrap_q;

endmodule
